hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Issue scheduler between the ID stage and the execute/writeback side of the RV64 core.
- Tracks the destination registers of in-flight instructions in a 32-entry scoreboard and stalls ID on RAW or WAW conflicts, or when the in-flight limit is reached.
- Suppresses issue on a redirect flush.
- Downstream stages then treat id_issue as the single "instruction accepted" qualifier.

Parameters:
- MAX_INFLIGHT, 4: maximum number of issued, not-yet-written-back register writes (1..31).
- CNT_W, 3: width of inflight_cnt; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising clk edge).
- id_valid  in  1  ID holds a decoded instruction.
- id_rs1_r_ena  in  1  rs1 is read.
- id_rs1_r_addr  in  5  rs1 index.
- id_rs2_r_ena  in  1  rs2 is read.
- id_rs2_r_addr  in  5  rs2 index.
- id_rd_w_ena  in  1  instruction writes rd.
- id_rd_w_addr  in  5  rd index.
- ex_flush  in  1  branch/jump redirect; kill the instruction in ID this cycle.
- wb_w_ena  in  1  writeback retires a register write this cycle.
- wb_w_addr  in  5  register being retired.
- id_stall  out  1  hold IF/ID this cycle.
- id_issue  out  1  instruction in ID is accepted this cycle.
- sb_pending  out  32  scoreboard, bit i = x[i] write outstanding.
- inflight_cnt  out  CNT_W  number of pending bits set.
- sb_err  out  1  sticky: writeback to a register that was not pending.

Behaviour:
- Reset (rst==0 at edge): sb_pending=0, inflight_cnt=0, sb_err=0. Hence id_stall=0, and id_issue follows id_valid after reset.
- Hit detection uses the registered sb_pending only:
  - raw1 = rs1_r_ena & rs1_addr!=0 & pending[rs1_addr]
  - raw2 = same for rs2
  - waw = rd_w_ena & rd_addr!=0 & pending[rd_addr]
  - full = (inflight_cnt==MAX_INFLIGHT) & rd_w_ena & rd_addr!=0
- A writeback in the same cycle does NOT release the stall. The register file write lands at the edge, so release happens the following cycle (one bubble minimum).
- id_stall = id_valid & ~ex_flush & (raw1|raw2|waw|full).
- id_issue = id_valid & ~ex_flush & ~id_stall. Combinational; zero-cycle latency.
- issue_w = id_issue & rd_w_ena & rd_addr!=0.
  - Sets pending[rd] at the edge.
  - Increments inflight_cnt.
- wb_clr = wb_w_ena & wb_addr!=0 & pending[wb_addr].
  - Clears that bit at the edge.
  - Decrements inflight_cnt.
- WB to a non-pending register, or to x0 with wb_w_ena: no state change, and sb_err sets if the address is nonzero. sb_err clears only on reset.
- Same-cycle issue_w and wb_clr:
  - Different registers: both apply; inflight_cnt is unchanged.
  - Same register: impossible, because waw blocks the issue.
- x0 is never pending; pending[0] is tied to 0.
- ex_flush dominates stall. The ID instruction is dropped (no issue, no scoreboard set). Existing pending bits are kept, because already-issued instructions still write back. WB is processed normally in a flush cycle.
- Invariant: inflight_cnt == popcount(sb_pending) at every edge. inflight_cnt never exceeds MAX_INFLIGHT and never wraps.
- Reset mid-operation discards all pending state. Downstream stages must be reset in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds output stall_cycles [`REG_BUS] and output flush_cycles [`REG_BUS].
  - Both reset to 0.
  - stall_cycles increments each cycle id_stall=1; flush_cycles increments each cycle ex_flush & id_valid.
  - Both saturate at all-ones (no wrap).
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Add to defines.v: `REG_NUM 32, `REG_ADDR_W 5, `MAX_INFLIGHT_DEF 4. `REG_BUS is reused.
- One sub-module, hazard_sb:
  - Contains the 32-bit scoreboard register, set/clear logic, inflight counter and sb_err.
  - Exposes the pending vector.
- hazard_ctrl keeps the hit comparators, the stall/issue equations and the optional perf counters.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 and random inputs → sb_pending=0, inflight_cnt=0, sb_err=0. First cycle after release: id_issue=1 for rd=x5.
- RAW: issue rd=x5, then next instr rs1=x5 → id_stall=1 each cycle until cycle after wb_w_ena=1, wb_w_addr=5; then id_issue=1, pending[5]=0.
- x0 / no-read: rd=x0 issue → sb_pending unchanged, inflight_cnt unchanged. rs2_r_ena=0 with rs2=x5 pending → no stall.
- Full: issue rd=x1..x4 back-to-back → inflight_cnt=4; rd=x6 stalls. Same-cycle wb x1 does not release. Next cycle id_issue=1 and cnt stays 4.
- Flush: pending x7, ID reads x7 with ex_flush=1 → id_stall=0, id_issue=0, pending[7] still 1. Simultaneous wb x7 clears it.
- Error/perf: wb_w_addr=9 not pending → sb_err=1 sticky. With HAZARD_PERF_EN, 3 stall cycles → stall_cycles=3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the hazard controller.
// The optional HAZARD_PERF_EN build uses `REG_BUS, which gets a fallback definition here.
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef MAX_INFLIGHT_DEF
`define MAX_INFLIGHT_DEF 4
`endif
`ifndef REG_BUS
`define REG_BUS 63:0
`endif

package hazard_ctrl_pkg;

  localparam int REG_NUM          = `REG_NUM;
  localparam int REG_ADDR_W       = `REG_ADDR_W;
  localparam int MAX_INFLIGHT_DEF = `MAX_INFLIGHT_DEF;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_NUM-1:0]    reg_vec_t;

  function automatic reg_vec_t onehot(input reg_addr_t addr);
    reg_vec_t one;
    one = {{(REG_NUM-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

  // x0 never counts as a hit, whatever the scoreboard holds
  function automatic logic reg_hit(input reg_vec_t pending, input logic ena, input reg_addr_t addr);
    return ena & (addr != 5'd0) & pending[addr];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/WB issue interface between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 3);
  import hazard_ctrl_pkg::*;

  logic      id_valid;
  logic      id_rs1_r_ena;
  reg_addr_t id_rs1_r_addr;
  logic      id_rs2_r_ena;
  reg_addr_t id_rs2_r_addr;
  logic      id_rd_w_ena;
  reg_addr_t id_rd_w_addr;
  logic      ex_flush;
  logic      wb_w_ena;
  reg_addr_t wb_w_addr;
  logic      id_stall;
  logic      id_issue;
  reg_vec_t  sb_pending;
  logic [CNT_W-1:0] inflight_cnt;
  logic      sb_err;

  modport master (
    output id_valid, id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
           id_rd_w_ena, id_rd_w_addr, ex_flush, wb_w_ena, wb_w_addr,
    input  id_stall, id_issue, sb_pending, inflight_cnt, sb_err
  );

  modport slave (
    input  id_valid, id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
           id_rd_w_ena, id_rd_w_addr, ex_flush, wb_w_ena, wb_w_addr,
    output id_stall, id_issue, sb_pending, inflight_cnt, sb_err
  );

endinterface

// File: rtl/hazard_ctrl_sb.sv
// Destination-register scoreboard: pending bits, in-flight counter and sticky
// error for writebacks to registers that were never issued.
module hazard_sb
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_w_i,
  input  reg_addr_t        issue_addr_i,
  input  logic             wb_w_ena_i,
  input  reg_addr_t        wb_w_addr_i,
  output reg_vec_t         pending_o,
  output logic [CNT_W-1:0] inflight_cnt_o,
  output logic             sb_err_o
);

  reg_vec_t         pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wb_nz_s, wb_clr_s, wb_bad_s;

  // Next-state: clear on retire, set on issue; issue never targets a pending reg
  always_comb begin
    wb_nz_s   = wb_w_ena_i & (wb_w_addr_i != 5'd0);
    wb_clr_s  = wb_nz_s & pending_q[wb_w_addr_i];
    wb_bad_s  = wb_nz_s & ~pending_q[wb_w_addr_i];
    pending_d = pending_q;
    if (wb_clr_s) begin
      pending_d = pending_d & ~onehot(wb_w_addr_i);
    end else begin
      pending_d = pending_d;
    end
    if (issue_w_i) begin
      pending_d = pending_d | onehot(issue_addr_i);
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
    case ({issue_w_i, wb_clr_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | wb_bad_s;
  end

  // Scoreboard state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= {REG_NUM{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o      = pending_q;
  assign inflight_cnt_o = cnt_q;
  assign sb_err_o       = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue scheduler between ID and EX/WB: RAW/WAW/in-flight-limit stalls and flush kill.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_cycles counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_if.slave    bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [`REG_BUS] stall_cycles,
  output logic [`REG_BUS] flush_cycles
`endif
);

  logic raw1_s, raw2_s, waw_s, full_s, rd_nz_s;
  logic stall_s, issue_s, issue_w_s;

  // Hazards look only at the registered scoreboard, so same-cycle WB never releases
  always_comb begin
    rd_nz_s   = bus.id_rd_w_ena & (bus.id_rd_w_addr != 5'd0);
    raw1_s    = reg_hit(bus.sb_pending, bus.id_rs1_r_ena, bus.id_rs1_r_addr);
    raw2_s    = reg_hit(bus.sb_pending, bus.id_rs2_r_ena, bus.id_rs2_r_addr);
    waw_s     = reg_hit(bus.sb_pending, bus.id_rd_w_ena, bus.id_rd_w_addr);
    full_s    = (bus.inflight_cnt == CNT_W'(MAX_INFLIGHT)) & rd_nz_s;
    stall_s   = bus.id_valid & ~bus.ex_flush & (raw1_s | raw2_s | waw_s | full_s);
    issue_s   = bus.id_valid & ~bus.ex_flush & ~stall_s;
    issue_w_s = issue_s & rd_nz_s;
  end

  assign bus.id_stall = stall_s;
  assign bus.id_issue = issue_s;

  hazard_sb #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_sb (
    .clk            (clk),
    .rst            (rst),
    .issue_w_i      (issue_w_s),
    .issue_addr_i   (bus.id_rd_w_addr),
    .wb_w_ena_i     (bus.wb_w_ena),
    .wb_w_addr_i    (bus.wb_w_addr),
    .pending_o      (bus.sb_pending),
    .inflight_cnt_o (bus.inflight_cnt),
    .sb_err_o       (bus.sb_err)
  );

`ifdef HAZARD_PERF_EN
  logic [`REG_BUS] stall_q, flush_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_s && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end else begin
        stall_q <= stall_q;
      end
      if (bus.ex_flush && bus.id_valid && !(&flush_q)) begin
        flush_q <= flush_q + 1'b1;
      end else begin
        flush_q <= flush_q;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change 1 time unit after
// the rising edge, combinational outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hazard_ctrl_if #(.CNT_W(3)) bus ();

`ifdef HAZARD_PERF_EN
  logic [`REG_BUS] stall_cycles;
  logic [`REG_BUS] flush_cycles;
`endif

  hazard_ctrl #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs1_r_ena  = 1'b0;
    bus.id_rs1_r_addr = 5'd0;
    bus.id_rs2_r_ena  = 1'b0;
    bus.id_rs2_r_addr = 5'd0;
    bus.id_rd_w_ena   = 1'b0;
    bus.id_rd_w_addr  = 5'd0;
    bus.ex_flush      = 1'b0;
    bus.wb_w_ena      = 1'b0;
    bus.wb_w_addr     = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic instr(input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                       input logic rde, input logic [4:0] rd);
    bus.id_valid      = 1'b1;
    bus.id_rs1_r_ena  = r1e;
    bus.id_rs1_r_addr = r1;
    bus.id_rs2_r_ena  = r2e;
    bus.id_rs2_r_addr = r2;
    bus.id_rd_w_ena   = rde;
    bus.id_rd_w_addr  = rd;
  endtask

  task automatic wb(input logic ena, input logic [4:0] addr);
    bus.wb_w_ena  = ena;
    bus.wb_w_addr = addr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.id_valid      = 1'b1;
    bus.id_rs1_r_ena  = 1'($urandom);
    bus.id_rs1_r_addr = 5'($urandom);
    bus.id_rs2_r_ena  = 1'($urandom);
    bus.id_rs2_r_addr = 5'($urandom);
    bus.id_rd_w_ena   = 1'($urandom);
    bus.id_rd_w_addr  = 5'($urandom);
    bus.ex_flush      = 1'b0;
    bus.wb_w_ena      = 1'($urandom);
    bus.wb_w_addr     = 5'($urandom);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.sb_pending !== 32'h0) begin miscompares++; $display("FAIL reset_pending: got %h want 0", bus.sb_pending); end
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bus.inflight_cnt); end
    vectors++; if (bus.sb_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.sb_err); end
    rst = 1'b1;
    idle();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    mid();
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL reset_first_issue: got %b want 1", bus.id_issue); end
    vectors++; if (bus.id_stall !== 1'b0) begin miscompares++; $display("FAIL reset_first_stall: got %b want 0", bus.id_stall); end
    step();
    vectors++; if (bus.sb_pending !== 32'h0000_0020) begin miscompares++; $display("FAIL reset_set_x5: got %h want 00000020", bus.sb_pending); end
    vectors++; if (bus.inflight_cnt !== 3'd1) begin miscompares++; $display("FAIL reset_cnt1: got %0d want 1", bus.inflight_cnt); end
  endtask

  task automatic test_raw();
    idle();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6);
    mid();
    vectors++; if (bus.id_stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall0: got %b want 1", bus.id_stall); end
    vectors++; if (bus.id_issue !== 1'b0) begin miscompares++; $display("FAIL raw_issue0: got %b want 0", bus.id_issue); end
    step();
    wb(1'b1, 5'd5);
    mid();
    vectors++; if (bus.id_stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall_same_wb: got %b want 1", bus.id_stall); end
    step();
    wb(1'b0, 5'd0);
    vectors++; if (bus.sb_pending[5] !== 1'b0) begin miscompares++; $display("FAIL raw_clear_x5: got %b want 0", bus.sb_pending[5]); end
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL raw_cnt0: got %0d want 0", bus.inflight_cnt); end
    mid();
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL raw_release: got %b want 1", bus.id_issue); end
    step();
    vectors++; if (bus.sb_pending !== 32'h0000_0040) begin miscompares++; $display("FAIL raw_set_x6: got %h want 00000040", bus.sb_pending); end
    idle();
    wb(1'b1, 5'd6);
    step();
    idle();
    vectors++; if (bus.sb_pending !== 32'h0) begin miscompares++; $display("FAIL raw_drain: got %h want 0", bus.sb_pending); end
  endtask

  task automatic test_x0_noread();
    idle();
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    mid();
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL x0_issue: got %b want 1", bus.id_issue); end
    step();
    vectors++; if (bus.sb_pending !== 32'h0) begin miscompares++; $display("FAIL x0_pending: got %h want 0", bus.sb_pending); end
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL x0_cnt: got %0d want 0", bus.inflight_cnt); end
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0);
    mid();
    vectors++; if (bus.id_stall !== 1'b0) begin miscompares++; $display("FAIL noread_stall: got %b want 0", bus.id_stall); end
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL noread_issue: got %b want 1", bus.id_issue); end
    step();
    instr(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd5);
    mid();
    vectors++; if (bus.id_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b want 1", bus.id_stall); end
    step();
    idle();
    wb(1'b1, 5'd5);
    step();
    idle();
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL x0_drain: got %0d want 0", bus.inflight_cnt); end
  endtask

  task automatic test_full();
    idle();
    for (int r = 1; r <= 4; r++) begin
      instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(r));
      mid();
      vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL full_b2b_issue x%0d: got %b want 1", r, bus.id_issue); end
      step();
    end
    vectors++; if (bus.inflight_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt4: got %0d want 4", bus.inflight_cnt); end
    vectors++; if (bus.sb_pending !== 32'h0000_001E) begin miscompares++; $display("FAIL full_pending: got %h want 0000001e", bus.sb_pending); end
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    mid();
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL full_rd_x0_issue: got %b want 1", bus.id_issue); end
    step();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6);
    mid();
    vectors++; if (bus.id_stall !== 1'b1) begin miscompares++; $display("FAIL full_stall: got %b want 1", bus.id_stall); end
    step();
    wb(1'b1, 5'd1);
    mid();
    vectors++; if (bus.id_stall !== 1'b1) begin miscompares++; $display("FAIL full_same_wb: got %b want 1", bus.id_stall); end
    step();
    wb(1'b0, 5'd0);
    vectors++; if (bus.inflight_cnt !== 3'd3) begin miscompares++; $display("FAIL full_cnt3: got %0d want 3", bus.inflight_cnt); end
    mid();
    vectors++; if (bus.id_issue !== 1'b1) begin miscompares++; $display("FAIL full_release: got %b want 1", bus.id_issue); end
    step();
    vectors++; if (bus.inflight_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt_back4: got %0d want 4", bus.inflight_cnt); end
    vectors++; if (bus.sb_pending !== 32'h0000_005C) begin miscompares++; $display("FAIL full_pending2: got %h want 0000005c", bus.sb_pending); end
    idle();
    // retire x2, then issue x8 while retiring x3: count stays put
    wb(1'b1, 5'd2);
    step();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
    wb(1'b1, 5'd3);
    step();
    idle();
    vectors++; if (bus.inflight_cnt !== 3'd3) begin miscompares++; $display("FAIL full_swap_cnt: got %0d want 3", bus.inflight_cnt); end
    vectors++; if (bus.sb_pending !== 32'h0000_0150) begin miscompares++; $display("FAIL full_swap_pending: got %h want 00000150", bus.sb_pending); end
    wb(1'b1, 5'd4); step();
    wb(1'b1, 5'd6); step();
    wb(1'b1, 5'd8); step();
    idle();
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", bus.inflight_cnt); end
  endtask

  task automatic test_flush();
    idle();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    step();
    instr(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd8);
    bus.ex_flush = 1'b1;
    mid();
    vectors++; if (bus.id_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", bus.id_stall); end
    vectors++; if (bus.id_issue !== 1'b0) begin miscompares++; $display("FAIL flush_issue: got %b want 0", bus.id_issue); end
    step();
    vectors++; if (bus.sb_pending !== 32'h0000_0080) begin miscompares++; $display("FAIL flush_keep_x7: got %h want 00000080", bus.sb_pending); end
    wb(1'b1, 5'd7);
    step();
    idle();
    vectors++; if (bus.sb_pending !== 32'h0) begin miscompares++; $display("FAIL flush_wb_clear: got %h want 0", bus.sb_pending); end
    vectors++; if (bus.inflight_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_cnt: got %0d want 0", bus.inflight_cnt); end
    vectors++; if (bus.sb_err !== 1'b0) begin miscompares++; $display("FAIL flush_err: got %b want 0", bus.sb_err); end
  endtask

  task automatic test_error();
    idle();
    wb(1'b1, 5'd0);
    step();
    vectors++; if (bus.sb_err !== 1'b0) begin miscompares++; $display("FAIL err_x0: got %b want 0", bus.sb_err); end
    wb(1'b1, 5'd9);
    step();
    idle();
    vectors++; if (bus.sb_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", bus.sb_err); end
    vectors++; if (bus.sb_pending !== 32'h0) begin miscompares++; $display("FAIL err_pending: got %h want 0", bus.sb_pending); end
    step();
    vectors++; if (bus.sb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", bus.sb_err); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++; if (bus.sb_err !== 1'b0) begin miscompares++; $display("FAIL err_reset: got %b want 0", bus.sb_err); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++; if (stall_cycles !== '0) begin miscompares++; $display("FAIL perf_stall_reset: got %0d want 0", stall_cycles); end
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    step();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) step();
    bus.ex_flush = 1'b1;
    repeat (2) step();
    idle();
    step();
    vectors++; if (stall_cycles !== 64'd3) begin miscompares++; $display("FAIL perf_stall: got %0d want 3", stall_cycles); end
    vectors++; if (flush_cycles !== 64'd2) begin miscompares++; $display("FAIL perf_flush: got %0d want 2", flush_cycles); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idle();
    test_reset();
    test_raw();
    test_x0_noread();
    test_full();
    test_flush();
    test_error();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
